// File: rtl/sc_spi_frame_buf.sv
// Upstream feeder / RX collector for the SPI controller: holds host TX/RX word buffers
// and sequences NFRAME+1 back-to-back frames through the SPISTART/SPIBUSY handshake.
module sc_spi_frame_buf #(
    parameter int unsigned AW = 4
) (
    input  logic          SPICLK,
    input  logic          SYSRST,
    input  logic          TXWE,
    input  logic [AW-1:0] TXWADDR,
    input  logic [31:0]   TXWDATA,
    input  logic [AW-1:0] RXRADDR,
    output logic [31:0]   RXRDATA,
    input  logic          GO,
    input  logic [3:0]    NFRAME,
    input  logic          HOLDCS,
    input  logic [8:0]    DWIDTH,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW:0]   RXCNT,
    output logic          ORERR,
    output logic          SPISTART,
    input  logic          SPIBUSY,
    output logic          CSEXTEND,
    input  logic [3:0]    TXDPT,
    output logic [31:0]   TXDATA,
    input  logic          RXVALID,
    input  logic [3:0]    RXDPT,
    input  logic [31:0]   RXDATA
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned DW    = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ACK, S_RUN, S_DRAIN, S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      nframe_q, nframe_d;
    logic            holdcs_q, holdcs_d;
    logic [8:0]      dwidth_q, dwidth_d;
    logic [AW-1:0]   base_q, base_d;
    logic [3:0]      fidx_q, fidx_d;
    logic            drain_q, drain_d;
    logic [AW:0]     rxcnt_q, rxcnt_d;
    logic            orerr_q, orerr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            spistart_q, spistart_d;
    logic [DW-1:0]   rxrdata_q;

    logic [DW-1:0]   txbuf_q [DEPTH];
    logic [DW-1:0]   rxbuf_q [DEPTH];

    logic [4:0]      wpf_c;
    logic [AW-1:0]   tx_raddr_c;
    logic [AW-1:0]   rx_waddr_c;
    logic            rx_we_c;
    logic            tx_we_c;

    assign wpf_c      = 5'(dwidth_q >> 5) + 5'd1;
    assign tx_raddr_c = base_q + AW'(TXDPT);
    assign rx_waddr_c = base_q + AW'(RXDPT);
    assign tx_we_c    = TXWE & ~busy_q;

    // Next-state, sequencing counters and RX bookkeeping
    always_comb begin
        state_d    = state_q;
        nframe_d   = nframe_q;
        holdcs_d   = holdcs_q;
        dwidth_d   = dwidth_q;
        base_d     = base_q;
        fidx_d     = fidx_q;
        drain_d    = drain_q;
        rxcnt_d    = rxcnt_q;
        orerr_d    = orerr_q;
        rx_we_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (GO) begin
                    nframe_d = NFRAME;
                    holdcs_d = HOLDCS;
                    dwidth_d = DWIDTH;
                    base_d   = '0;
                    fidx_d   = '0;
                    rxcnt_d  = '0;
                    orerr_d  = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: state_d = S_ACK;
            S_ACK: begin
                if (SPIBUSY) state_d = S_RUN;
            end
            S_RUN: begin
                if (!SPIBUSY) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Two cycles here let the controller's last RX word land before rebasing
                if (drain_q) begin
                    if (fidx_q == nframe_q) begin
                        state_d = S_FIN;
                    end else begin
                        fidx_d  = fidx_q + 4'd1;
                        base_d  = base_q + AW'(wpf_c);
                        state_d = S_START;
                    end
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (RXVALID) begin
            if (state_q == S_RUN || state_q == S_DRAIN) begin
                rx_we_c = 1'b1;
                if (rxcnt_q != (AW+1)'(DEPTH)) rxcnt_d = rxcnt_q + (AW+1)'(1);
            end else begin
                orerr_d = 1'b1;
            end
        end

        busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
        spistart_d = (state_d == S_START);
        done_d     = (state_d == S_FIN);
    end

    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            state_q    <= S_IDLE;
            nframe_q   <= '0;
            holdcs_q   <= 1'b0;
            dwidth_q   <= '0;
            base_q     <= '0;
            fidx_q     <= '0;
            drain_q    <= 1'b0;
            rxcnt_q    <= '0;
            orerr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spistart_q <= 1'b0;
            rxrdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            nframe_q   <= nframe_d;
            holdcs_q   <= holdcs_d;
            dwidth_q   <= dwidth_d;
            base_q     <= base_d;
            fidx_q     <= fidx_d;
            drain_q    <= drain_d;
            rxcnt_q    <= rxcnt_d;
            orerr_q    <= orerr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spistart_q <= spistart_d;
            rxrdata_q  <= rxbuf_q[RXRADDR];
        end
    end

    // Word buffers are intentionally left unreset
    always_ff @(posedge SPICLK) begin
        if (tx_we_c) txbuf_q[TXWADDR] <= TXWDATA;
        if (rx_we_c) rxbuf_q[rx_waddr_c] <= RXDATA;
    end

    assign TXDATA   = txbuf_q[tx_raddr_c];
    assign RXRDATA  = rxrdata_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RXCNT    = rxcnt_q;
    assign ORERR    = orerr_q;
    assign SPISTART = spistart_q;
    assign CSEXTEND = busy_q & ((fidx_q != nframe_q) | holdcs_q);

endmodule

// File: tb/tb_sc_spi_frame_buf.sv
// Bench for sc_spi_frame_buf: emulates the SPI controller and checks against a
// slot-level model of the TX/RX buffers.
module tb_sc_spi_frame_buf;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          SPICLK;
    logic          SYSRST;
    logic          TXWE;
    logic [AW-1:0] TXWADDR;
    logic [31:0]   TXWDATA;
    logic [AW-1:0] RXRADDR;
    logic [31:0]   RXRDATA;
    logic          GO;
    logic [3:0]    NFRAME;
    logic          HOLDCS;
    logic [8:0]    DWIDTH;
    logic          BUSY;
    logic          DONE;
    logic [AW:0]   RXCNT;
    logic          ORERR;
    logic          SPISTART;
    logic          SPIBUSY;
    logic          CSEXTEND;
    logic [3:0]    TXDPT;
    logic [31:0]   TXDATA;
    logic          RXVALID;
    logic [3:0]    RXDPT;
    logic [31:0]   RXDATA;

    sc_spi_frame_buf #(.AW(AW)) dut (
        .SPICLK(SPICLK), .SYSRST(SYSRST),
        .TXWE(TXWE), .TXWADDR(TXWADDR), .TXWDATA(TXWDATA),
        .RXRADDR(RXRADDR), .RXRDATA(RXRDATA),
        .GO(GO), .NFRAME(NFRAME), .HOLDCS(HOLDCS), .DWIDTH(DWIDTH),
        .BUSY(BUSY), .DONE(DONE), .RXCNT(RXCNT), .ORERR(ORERR),
        .SPISTART(SPISTART), .SPIBUSY(SPIBUSY), .CSEXTEND(CSEXTEND),
        .TXDPT(TXDPT), .TXDATA(TXDATA),
        .RXVALID(RXVALID), .RXDPT(RXDPT), .RXDATA(RXDATA)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_tx [DEPTH];
    logic [31:0] m_rx [DEPTH];
    bit          m_rx_ok [DEPTH];

    initial SPICLK = 1'b0;
    always #5 SPICLK = ~SPICLK;

    task automatic tick;
        @(posedge SPICLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        TXWE = 1'b1; TXWADDR = AW'(a); TXWDATA = d;
        tick;
        TXWE = 1'b0;
        m_tx[a] = d;
    endtask

    task automatic readback;
        for (int a = 0; a < int'(DEPTH); a++) begin
            RXRADDR = AW'(a);
            tick;
            if (m_rx_ok[a]) chk("rx_readback", RXRDATA, m_rx[a]);
        end
    endtask

    // One frame as the controller sees it: start pulse, busy window, WPF words
    task automatic run_frame(input int f, input int nf, input int wpf, input bit hold, input bit inject);
        int base;
        bit late;
        logic [31:0] d;
        base = (f * wpf) % DEPTH;
        for (int i = 0; i < 20 && !SPISTART; i++) tick;
        chk("spistart_seen", SPISTART, 1);
        chk("csext_frame", CSEXTEND, ((f != nf) || hold) ? 1 : 0);
        chk("busy_frame", BUSY, 1);
        tick;
        chk("spistart_pulse", SPISTART, 0);
        repeat ($urandom_range(0, 2)) tick;
        SPIBUSY = 1'b1;
        tick;
        if (inject) begin
            GO = 1'b1; TXWE = 1'b1; TXWADDR = AW'($urandom); TXWDATA = $urandom;
            tick;
            GO = 1'b0; TXWE = 1'b0;
        end
        late = 1'($urandom_range(0, 1));
        for (int w = 0; w < wpf; w++) begin
            if (late && w == wpf - 1) begin
                SPIBUSY = 1'b0;
                tick;
            end
            TXDPT = 4'(w);
            #1;
            chk("txdata", TXDATA, m_tx[(base + w) % DEPTH]);
            if (w == 0) chk("csext_run", CSEXTEND, ((f != nf) || hold) ? 1 : 0);
            d = $urandom;
            RXVALID = 1'b1; RXDPT = 4'(w); RXDATA = d;
            m_rx[(base + w) % DEPTH] = d;
            m_rx_ok[(base + w) % DEPTH] = 1'b1;
            tick;
            RXVALID = 1'b0;
        end
        SPIBUSY = 1'b0;
    endtask

    task automatic run_seq(input int nf, input logic [8:0] dw, input bit hold, input bit inject);
        int wpf;
        int total;
        wpf = int'(dw[8:5]) + 1;
        total = (nf + 1) * wpf;
        NFRAME = 4'(nf); HOLDCS = hold; DWIDTH = dw; GO = 1'b1;
        tick;
        GO = 1'b0;
        chk("busy_go", BUSY, 1);
        chk("orerr_go", ORERR, 0);
        chk("rxcnt_go", RXCNT, 0);
        for (int f = 0; f <= nf; f++) run_frame(f, nf, wpf, hold, inject && f == 0);
        for (int i = 0; i < 20 && !DONE; i++) tick;
        chk("done_seen", DONE, 1);
        chk("busy_fin", BUSY, 0);
        chk("csext_fin", CSEXTEND, 0);
        chk("orerr_fin", ORERR, 0);
        chk("rxcnt_fin", RXCNT, (total > int'(DEPTH)) ? DEPTH : total);
        tick;
        chk("done_pulse", DONE, 0);
        readback();
    endtask

    initial begin
        SYSRST = 1'b1; TXWE = 1'b0; TXWADDR = '0; TXWDATA = '0; RXRADDR = '0;
        GO = 1'b0; NFRAME = '0; HOLDCS = 1'b0; DWIDTH = '0; SPIBUSY = 1'b0;
        TXDPT = '0; RXVALID = 1'b0; RXDPT = '0; RXDATA = '0;
        for (int a = 0; a < int'(DEPTH); a++) m_rx_ok[a] = 1'b0;
        tick; tick;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_spistart", SPISTART, 0);
        chk("rst_csext", CSEXTEND, 0);
        chk("rst_orerr", ORERR, 0);
        chk("rst_rxcnt", RXCNT, 0);
        chk("rst_rxrdata", RXRDATA, 0);
        SYSRST = 1'b0;
        tick;

        host_write(0, 32'hA5A5_0001);
        for (int a = 1; a < int'(DEPTH); a++) host_write(a, $urandom);

        run_seq(0, 9'd31, 1'b0, 1'b0);
        run_seq(2, 9'd63, 1'b0, 1'b0);
        run_seq(4, 9'd127, 1'b0, 1'b0);

        // RXVALID outside a sequence must flag and must not write
        RXVALID = 1'b1; RXDPT = 4'd3; RXDATA = 32'hDEAD_BEEF;
        tick;
        RXVALID = 1'b0;
        chk("orerr_idle", ORERR, 1);
        readback();

        run_seq(1, 9'd63, 1'b1, 1'b1);

        // Reset in the middle of a held-CS sequence
        NFRAME = 4'd3; HOLDCS = 1'b1; DWIDTH = 9'd31; GO = 1'b1;
        tick;
        GO = 1'b0;
        tick;
        SPIBUSY = 1'b1;
        tick;
        chk("csext_pre_rst", CSEXTEND, 1);
        SYSRST = 1'b1;
        #1;
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_spistart", SPISTART, 0);
        chk("rst_mid_csext", CSEXTEND, 0);
        chk("rst_mid_rxcnt", RXCNT, 0);
        tick;
        SYSRST = 1'b0;
        SPIBUSY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("post_rst_done", DONE, 0);
            chk("post_rst_spistart", SPISTART, 0);
        end
        run_seq(0, 9'd95, 1'b0, 1'b0);

        for (int s = 0; s < 6; s++) begin
            host_write($urandom_range(0, DEPTH - 1), $urandom);
            run_seq($urandom_range(0, 5), 9'($urandom_range(0, 511)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
